// File: rtl/mosq_pkg.sv
// Shared types and default parameters for the mosquito temporal decision stage.
package mosq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ON_HOLD = 2'd1,
    ON      = 2'd2
  } mosq_dec_state_t;

  localparam int unsigned MOSQ_WIN     = 16;
  localparam int unsigned MOSQ_ON_THR  = 10;
  localparam int unsigned MOSQ_OFF_THR = 4;
  localparam int unsigned MOSQ_HOLD    = 32;

endpackage

// File: rtl/mosq_decision_hit_window.sv
// Sliding window of the last WIN accepted hit flags with a running hit count.
module hit_window #(
  parameter int unsigned WIN = 16,
  parameter int unsigned CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_en,
  input  logic          is_large,
  output logic [CW-1:0] cnt_next,
  output logic [CW-1:0] hit_cnt
);

  logic [WIN-1:0] hist_q, hist_d;
  logic [CW-1:0]  cnt_q,  cnt_d;

  // Incoming hit added, bit falling off the far end removed; stays in 0..WIN.
  always_comb begin
    cnt_next = cnt_q + CW'(is_large) - CW'(hist_q[WIN-1]);
    hist_d   = hist_q;
    cnt_d    = cnt_q;
    if (in_en) begin
      hist_d = {hist_q[WIN-2:0], is_large};
      cnt_d  = cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hit_cnt = cnt_q;

endmodule

// File: rtl/mosq_decision.sv
// M-of-N window plus on/off hysteresis producing the mosquito-present flag.
// Optional minimum hold time after assertion: define MOSQ_DECISION_HOLD_EN.
module mosq_decision
  import mosq_pkg::*;
#(
  parameter int unsigned WIN     = MOSQ_WIN,
  parameter int unsigned ON_THR  = MOSQ_ON_THR,
  parameter int unsigned OFF_THR = MOSQ_OFF_THR,
  parameter int unsigned HOLD    = MOSQ_HOLD,
  localparam int unsigned CW     = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_en,
  input  logic          is_large,
  output logic          detect,
  output logic          det_rise,
  output logic [CW-1:0] hit_cnt,
  output logic          out_en
);

  localparam logic [CW-1:0] ON_THR_C  = CW'(ON_THR);
  localparam logic [CW-1:0] OFF_THR_C = CW'(OFF_THR);

  logic [CW-1:0]   cnt_next;
  mosq_dec_state_t state_q, state_d;
  logic            detect_q, detect_d;
  logic            det_rise_q, det_rise_d;
  logic            out_en_q, out_en_d;

`ifdef MOSQ_DECISION_HOLD_EN
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  hit_window #(
    .WIN (WIN),
    .CW  (CW)
  ) u_hit_window (
    .clk      (clk),
    .rst      (rst),
    .in_en    (in_en),
    .is_large (is_large),
    .cnt_next (cnt_next),
    .hit_cnt  (hit_cnt)
  );

  always_comb begin
    state_d    = state_q;
    det_rise_d = 1'b0;
    out_en_d   = in_en;
`ifdef MOSQ_DECISION_HOLD_EN
    hold_d     = hold_q;
`endif
    if (in_en) begin
      unique case (state_q)
        IDLE: begin
          if (cnt_next >= ON_THR_C) begin
`ifdef MOSQ_DECISION_HOLD_EN
            state_d = ON_HOLD;
            hold_d  = HOLD_INIT;
`else
            state_d = ON;
`endif
            det_rise_d = 1'b1;
          end
        end
        ON_HOLD: begin
`ifdef MOSQ_DECISION_HOLD_EN
          if (hold_q == '0) state_d = ON;
          else              hold_d  = hold_q - 1'b1;
`else
          state_d = IDLE;
`endif
        end
        ON: begin
          if (cnt_next <= OFF_THR_C) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    detect_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      detect_q   <= 1'b0;
      det_rise_q <= 1'b0;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      detect_q   <= detect_d;
      det_rise_q <= det_rise_d;
      out_en_q   <= out_en_d;
    end
  end

`ifdef MOSQ_DECISION_HOLD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  assign detect   = detect_q;
  assign det_rise = det_rise_q;
  assign out_en   = out_en_q;

endmodule

// File: tb/tb_mosq_decision.sv
// Directed self-checking bench for mosq_decision at default parameters.
module tb_mosq_decision;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_en;
  logic       is_large;
  logic       detect;
  logic       det_rise;
  logic [4:0] hit_cnt;
  logic       out_en;

  int checks   = 0;
  int failures = 0;

`ifdef MOSQ_DECISION_HOLD_EN
  localparam int DROP_FRAME = 43;
`else
  localparam int DROP_FRAME = 22;
`endif

  mosq_decision #(
    .WIN     (16),
    .ON_THR  (10),
    .OFF_THR (4),
    .HOLD    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_en    (in_en),
    .is_large (is_large),
    .detect   (detect),
    .det_rise (det_rise),
    .hit_cnt  (hit_cnt),
    .out_en   (out_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic hit);
    in_en    = 1'b1;
    is_large = hit;
    step();
  endtask

  task automatic idle(input int n);
    in_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_detect"},   32'(detect),   0);
    check({tag, "_det_rise"}, 32'(det_rise), 0);
    check({tag, "_hit_cnt"},  32'(hit_cnt),  0);
    check({tag, "_out_en"},   32'(out_en),   0);
  endtask

  initial begin
    rst      = 1'b1;
    in_en    = 1'b0;
    is_large = 1'b0;
    step();
    step();
    rst = 1'b0;
    idle(5);
    check_all_zero("reset_idle");

    // 10 consecutive hits: rise on the 10th frame's output cycle
    for (int f = 1; f <= 10; f++) begin
      frame(1'b1);
      check($sformatf("ramp_out_en_f%0d", f), 32'(out_en), 1);
      check($sformatf("ramp_cnt_f%0d", f), 32'(hit_cnt), 32'(f));
      check($sformatf("ramp_detect_f%0d", f), 32'(detect), (f == 10) ? 1 : 0);
      check($sformatf("ramp_rise_f%0d", f), 32'(det_rise), (f == 10) ? 1 : 0);
    end

    // is_large high without in_en: nothing moves, pulse gone
    is_large = 1'b1;
    in_en    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("gap_out_en_%0d", i), 32'(out_en), 0);
      check($sformatf("gap_cnt_%0d", i), 32'(hit_cnt), 10);
      check($sformatf("gap_rise_%0d", i), 32'(det_rise), 0);
      check($sformatf("gap_detect_%0d", i), 32'(detect), 1);
    end

    // zeros after the 10 hits: count holds through 16, decays from 17
    for (int f = 11; f <= 45; f++) begin
      int exp_cnt;
      exp_cnt = (f <= 16) ? 10 : ((f - 16 >= 10) ? 0 : 10 - (f - 16));
      frame(1'b0);
      check($sformatf("decay_cnt_f%0d", f), 32'(hit_cnt), 32'(exp_cnt));
      check($sformatf("decay_detect_f%0d", f), 32'(detect), (f < DROP_FRAME) ? 1 : 0);
      check($sformatf("decay_rise_f%0d", f), 32'(det_rise), 0);
    end

    // alternating hits from clean history: count saturates at 8, never detects
    idle(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int f = 1; f <= 40; f++) begin
      frame((f % 2) == 1);
      check($sformatf("alt_cnt_f%0d", f), 32'(hit_cnt), (f <= 16) ? 32'((f + 1) / 2) : 8);
      check($sformatf("alt_detect_f%0d", f), 32'(detect), 0);
    end

    // mid-operation asynchronous reset
    idle(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int f = 1; f <= 12; f++) frame(1'b1);
    check("pre_rst_cnt", 32'(hit_cnt), 12);
    check("pre_rst_detect", 32'(detect), 1);
    in_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    rst = 1'b0;
    for (int f = 1; f <= 9; f++) begin
      frame(1'b1);
      check($sformatf("post_rst_cnt_f%0d", f), 32'(hit_cnt), 32'(f));
      check($sformatf("post_rst_detect_f%0d", f), 32'(detect), 0);
    end
    frame(1'b1);
    check("post_rst_cnt_f10", 32'(hit_cnt), 10);
    check("post_rst_detect_f10", 32'(detect), 1);
    check("post_rst_rise_f10", 32'(det_rise), 1);
    idle(1);
    check("post_rst_rise_clear", 32'(det_rise), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
